// File: rtl/radix4_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : radix4_booth_multiplier
// Brief   : Sequential signed NxN multiplier, radix-4 Booth, 2 bits per clock.
// Revision: 1.0
// ============================================================================
module radix4_booth_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int C_ITERS = N / 2;
  localparam int C_CNT_W = $clog2(C_ITERS) + 1;
  localparam logic [C_CNT_W-1:0] C_LAST_ITER = C_CNT_W'(C_ITERS - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               start_prev_q, start_prev_d;
  logic [N+1:0]       acc_q, acc_d;
  logic [N:0]         mul_q, mul_d;
  logic [N-1:0]       mcand_q, mcand_d;
  logic [C_CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]     product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               w_start_edge;
  logic [N+1:0]       w_a_ext;
  logic [N+1:0]       w_addend;
  logic [N+1:0]       w_sum;
  logic [2*N+2:0]     w_shifted;

  assign w_start_edge = start & ~start_prev_q;
  assign w_a_ext      = {{2{mcand_q[N-1]}}, mcand_q};

  // Booth digit from the low triplet of the multiplier register.
  always_comb begin
    w_addend = '0;
    case (mul_q[2:0])
      3'b001, 3'b010: w_addend = w_a_ext;
      3'b011:         w_addend = w_a_ext << 1;
      3'b100:         w_addend = -(w_a_ext << 1);
      3'b101, 3'b110: w_addend = -w_a_ext;
      default:        w_addend = '0;
    endcase
  end

  assign w_sum = acc_q + w_addend;
  // Arithmetic shift of {sum, multiplier} by two, replicating the sign.
  assign w_shifted = {{2{w_sum[N+1]}}, w_sum, mul_q[N:2]};

  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    acc_d        = acc_q;
    mul_d        = mul_q;
    mcand_d      = mcand_q;
    cnt_d        = cnt_q;
    product_d    = product_q;
    busy_d       = busy_q;
    done_d       = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_start_edge) begin
          state_d = S_RUN;
          acc_d   = '0;
          mul_d   = {b, 1'b0};
          mcand_d = a;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_RUN: begin
        acc_d = w_shifted[2*N+2:N+1];
        mul_d = w_shifted[N:0];
        cnt_d = cnt_q + C_CNT_ONE;
        if (cnt_q == C_LAST_ITER) begin
          // Drop the Booth guard bit; the low 2N bits are the exact product.
          product_d = w_shifted[2*N:1];
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      // Held high so a start level present at reset release is not an edge.
      start_prev_q <= 1'b1;
      acc_q        <= '0;
      mul_q        <= '0;
      mcand_q      <= '0;
      cnt_q        <= '0;
      product_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      acc_q        <= acc_d;
      mul_q        <= mul_d;
      mcand_q      <= mcand_d;
      cnt_q        <= cnt_d;
      product_q    <= product_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_radix4_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module  : tb_radix4_booth_multiplier
// Brief   : Scoreboard bench for radix4_booth_multiplier, directed vectors.
// Revision: 1.0
// ============================================================================
module tb_radix4_booth_multiplier;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  logic        done_prev = 1'b0;
  logic [15:0] exp_prod_q[$];
  int          exp_cyc_q[$];

  radix4_booth_multiplier #(.N(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Monitor: on every rise of done, pop the scoreboard and compare.
  always @(negedge clk) begin
    check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
    if (done && !done_prev) begin
      if (exp_prod_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        check("product", {16'd0, product}, {16'd0, exp_prod_q.pop_front()});
        check("latency_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    done_prev <= done;
  end

  // Start pulse issued at a negedge; capture is the next posedge, done 4 edges later.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expv);
    a = av;
    b = bv;
    start = 1'b1;
    exp_prod_q.push_back(expv);
    exp_cyc_q.push_back(cyc + 5);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("reset_product", {16'd0, product}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 7 x -3
    start_op(8'd7, 8'hFD, 16'hFFEB);
    check("busy_after_capture", {31'd0, busy}, 32'd1);
    wait_done();
    repeat (3) @(negedge clk);
    check("done_holds", {31'd0, done}, 32'd1);
    check("product_holds", {16'd0, product}, 32'h0000FFEB);

    // Corner products
    start_op(8'h80, 8'h80, 16'h4000); wait_done();
    start_op(8'h80, 8'h7F, 16'hC080); wait_done();
    start_op(8'h00, 8'hFF, 16'h0000); wait_done();
    start_op(8'hFF, 8'hFF, 16'h0001); wait_done();

    // Generator sequence: reset 1, low 1, start high 3 cycles
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    a = 8'd5;
    b = 8'd6;
    start = 1'b1;
    exp_prod_q.push_back(16'h001E);
    exp_cyc_q.push_back(cyc + 5);
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done();

    // Second start edge during RUN is ignored
    start_op(8'd3, 8'd4, 16'h000C);
    @(negedge clk);
    a = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Restart from DONE: done drops, old product held
    start_op(8'hFE, 8'd50, 16'hFF9C);
    check("restart_done_clear", {31'd0, done}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    check("restart_product_held", {16'd0, product}, 32'h0000000C);
    wait_done();

    // Reset on iteration 2, start held high across reset release
    a = 8'd7;
    b = 8'd7;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_product", {16'd0, product}, 32'd0);
    check("midrun_reset_busy", {31'd0, busy}, 32'd0);
    check("midrun_reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("held_start_no_busy", {31'd0, busy}, 32'd0);
    check("held_start_no_done", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    start_op(8'hFB, 8'd9, 16'hFFD3);
    wait_done();

    @(negedge clk);
    check("scoreboard_empty", exp_prod_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/radix4_booth_multiplier.md
# radix4_booth_multiplier

Sequential signed multiplier that answers the start/reset sequence issued by the test-sequence generator. It captures two signed N-bit operands on a rising edge of `start` and retires two multiplier bits per clock using radix-4 (modified Booth) recoding. It then presents the exact 2N-bit product with a `done` flag. It is the consumer end of the start/reset handshake: the generator drives `reset` and `start`, and this block executes the operation they request.

## Interface
- `N`, default 8, operand width; must be even and at least 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  request; only a 0→1 transition is acted on, and the level may stay high for any number of cycles.
- `a`  in  N  multiplicand, signed two's complement.
- `b`  in  N  multiplier, signed two's complement.
- `product`  out  2N  signed result a×b; holds the last completed result.
- `busy`  out  1  high while iterations are running.
- `done`  out  1  high from completion until the next accepted start or reset.

## Operation
- One clock and one synchronous active-high reset, named `clk` and `reset`.
- **Start edge detection**
  - A registered copy `start_d` is kept.
  - An edge is `start & ~start_d`.
  - Reset sets `start_d` to 1, so a `start` held high through reset release does not trigger. A low cycle is required first.
- **States**
  - IDLE: waiting. An edge loads operands and moves to RUN.
  - RUN: N/2 iteration cycles, then moves to DONE.
  - DONE: waiting. An edge loads operands and returns to RUN.
- **Load**
  - Accumulator = 0, with width N+2 so it can hold ±2A without overflow.
  - Multiplier register = {b, 1'b0}.
  - Multiplicand register = a.
  - Iteration counter = 0.
- **Iteration**
  - Examine the low 3 bits of the multiplier register:
    - 000 or 111 → add 0
    - 001 or 010 → add +A
    - 011 → add +2A
    - 100 → add −2A
    - 101 or 110 → add −A
  - A is sign-extended to N+2 bits.
  - Then arithmetic-shift the concatenated {accumulator, multiplier} right by 2, replicating the accumulator sign.
  - Increment the counter.
- **Completion**
  - On the N/2-th iteration the final shifted value is written into `product` (2N bits, exact, no saturation).
  - `done` goes to 1 and `busy` goes to 0.
- **Operands**: `a` and `b` are sampled only on the load edge. Later changes have no effect on the operation in flight.
- **Start edge during RUN**: ignored, with no restart and no queuing.
- **Start edge in DONE**: `done` clears on that same edge, `busy` rises, and `product` keeps its old value until the new completion.
- **Reset**
  - Reset in any state, including mid-RUN, takes effect on the next edge: state IDLE, `product`=0, `busy`=0, `done`=0, and the counter and working registers are cleared.
  - Reset has priority over `start`.

## Timing
- Reset values: `product`=0, `busy`=0, `done`=0, state IDLE, `start_d`=1.
- Capture edge k is the clock edge where `start`=1 and `start_d`=0.
- After edge k: `busy`=1.
- Iterations occur on edges k+1 … k+N/2.
- After edge k+N/2: `product` is valid, `done`=1, `busy`=0. Latency is N/2 cycles (4 for N=8).
- `busy` and `done` are never high together.
- Minimum restart interval: an edge accepted at k+N/2+1 is legal. This needs `start` low at some sampled edge after the previous capture.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Basic: N=8, reset 1 cycle, then a=7, b=−3 and a start pulse → `busy` for 4 cycles, then `product`=16'hFFEB (−21) and `done`=1, which holds while `start` stays low.
- Corner products: a=−128, b=−128 → 16'h4000; a=−128, b=127 → 16'hC080; a=0, b=−1 → 16'h0000; a=−1, b=−1 → 16'h0001.
- Generator sequence: `reset` high 1 cycle, low 1 cycle, then `start` high for 3 cycles with a=5, b=6 → exactly one operation, `product`=16'h001E, and a single rise of `done`.
- Ignore during run: a=3, b=4 start, then another `start` edge two cycles later with a=9 → result 16'h000C at the original latency; no second operation.
- Restart from DONE: after a completed 3×4, start with a=−2, b=50 → `done` drops on the capture edge and the old `product` is held. After 4 cycles `product`=16'hFF9C.
- Reset mid-run and across start: assert `reset` on iteration 2 → all outputs 0 and IDLE on the next edge. Hold `start` high while deasserting `reset` → no operation until `start` goes low and then high again.
